// File: rtl/foc_pkg.sv
// Shared defaults and wide signed helpers for the angle tracking path.
// Helpers work on a 64-bit signed carrier; callers narrow the result.
package foc_pkg;

  localparam int ANGLE_W_DEF   = 12;
  localparam int TURN_W_DEF    = 20;
  localparam int POS_DIV_DEF   = 400;
  localparam int VEL_DIV_DEF   = 40000;
  localparam int FILT_LOG2_DEF = 2;

  localparam int HW = 64;
  typedef logic signed [HW-1:0] wide_t;

  // Shortest signed step between two w-bit angles.
  function automatic wide_t wrap_delta(
    input wide_t a,
    input wide_t b,
    input int    w
  );
    wide_t m;
    wide_t d;
    m = (wide_t'(1) <<< w) - wide_t'(1);
    d = (a - b) & m;
    if (d[w-1]) d = d - m - wide_t'(1);
    return d;
  endfunction

  function automatic wide_t sat(
    input wide_t v,
    input int    w
  );
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(
    input wide_t v,
    input int    w
  );
    return sat(v, w) != v;
  endfunction

endpackage

// File: rtl/mavg_filter.sv
// Moving average over 2^LOG2 strobed samples.
// Circular delay line with a running sum one bit-group wider than the data.
module mavg_filter
  import foc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2  = FILT_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    strobe_in,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout,
  output logic                    strobe_out
);

  localparam int DEPTH = 1 << LOG2;
  localparam int SUM_W = WIDTH + LOG2;
  localparam int PTR_W = (LOG2 > 0) ? LOG2 : 1;

  logic signed [WIDTH-1:0] line [DEPTH];
  logic [PTR_W-1:0]        ptr;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_nx;

  always_comb begin
    sum_nx = sum + SUM_W'(din) - SUM_W'(line[ptr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      ptr        <= '0;
      dout       <= '0;
      strobe_out <= 1'b0;
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else if (clear) begin
      sum        <= '0;
      ptr        <= '0;
      dout       <= '0;
      strobe_out <= 1'b0;
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      strobe_out <= strobe_in;
      if (strobe_in) begin
        line[ptr] <= din;
        sum       <= sum_nx;
        dout      <= WIDTH'(sum_nx >>> LOG2);
        if (ptr == PTR_W'(DEPTH - 1)) ptr <= '0;
        else                          ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/angle_tracker.sv
// Multi-turn position unwrapper with saturating accumulator
// and averaged velocity estimate.
module angle_tracker
  import foc_pkg::*;
#(
  parameter int ANGLE_W   = ANGLE_W_DEF,
  parameter int TURN_W    = TURN_W_DEF,
  parameter int POS_DIV   = POS_DIV_DEF,
  parameter int VEL_DIV   = VEL_DIV_DEF,
  parameter int FILT_LOG2 = FILT_LOG2_DEF,
  parameter int POS_W     = ANGLE_W + TURN_W
) (
  input  logic                    I_clk,
  input  logic                    I_rstn,
  input  logic [ANGLE_W-1:0]      I_angle,
  input  logic                    I_dir,
  input  logic                    I_clear,
  output logic signed [POS_W-1:0] O_position,
  output logic                    O_pos_valid,
  output logic signed [POS_W-1:0] O_velocity,
  output logic                    O_vel_valid,
  output logic                    O_sat
);

  localparam int PC_W = $clog2(POS_DIV);
  localparam int VC_W = $clog2(VEL_DIV);

  logic [PC_W-1:0]         pos_cnt;
  logic [VC_W-1:0]         vel_cnt;
  logic                    pos_tick;
  logic                    vel_tick;
  logic                    pos_first;
  logic                    vel_first;
  logic                    push;
  logic [ANGLE_W-1:0]      ang;
  logic [ANGLE_W-1:0]      a_prev;
  logic signed [POS_W-1:0] p_ref;
  logic signed [POS_W-1:0] pos_new;
  logic signed [POS_W-1:0] vel_d;
  logic                    pos_hit;
  wide_t                   pos_sum;

  assign pos_tick = pos_cnt == PC_W'(POS_DIV - 1);
  assign vel_tick = vel_cnt == VC_W'(VEL_DIV - 1);
  assign push     = vel_tick & ~vel_first & ~I_clear;

  always_comb begin
    ang     = I_dir ? ANGLE_W'(0) - I_angle : I_angle;
    pos_sum = wide_t'(O_position)
            + wrap_delta(wide_t'(ang), wide_t'(a_prev), ANGLE_W);
    pos_new = POS_W'(sat(pos_sum, POS_W));
    pos_hit = sat_hit(pos_sum, POS_W);
    vel_d   = POS_W'(sat(wide_t'(O_position) - wide_t'(p_ref), POS_W));
  end

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      pos_cnt <= '0;
      vel_cnt <= '0;
    end else if (I_clear) begin
      pos_cnt <= '0;
      vel_cnt <= '0;
    end else begin
      pos_cnt <= pos_tick ? '0 : pos_cnt + 1'b1;
      vel_cnt <= vel_tick ? '0 : vel_cnt + 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      O_position  <= '0;
      O_pos_valid <= 1'b0;
      O_sat       <= 1'b0;
      a_prev      <= '0;
      pos_first   <= 1'b1;
    end else if (I_clear) begin
      O_position  <= '0;
      O_pos_valid <= 1'b0;
      O_sat       <= 1'b0;
      a_prev      <= '0;
      pos_first   <= 1'b1;
    end else begin
      O_pos_valid <= pos_tick;
      if (pos_tick) begin
        a_prev    <= ang;
        pos_first <= 1'b0;
        if (pos_first) begin
          O_position <= {{TURN_W{1'b0}}, ang};
        end else begin
          O_position <= pos_new;
          if (pos_hit) O_sat <= 1'b1;
        end
      end
    end
  end

  // p_ref samples the pre-update position even on a shared tick.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      p_ref     <= '0;
      vel_first <= 1'b1;
    end else if (I_clear) begin
      p_ref     <= '0;
      vel_first <= 1'b1;
    end else if (vel_tick) begin
      p_ref     <= O_position;
      vel_first <= 1'b0;
    end
  end

  mavg_filter #(
    .WIDTH (POS_W),
    .LOG2  (FILT_LOG2)
  ) u_mavg (
    .clk        (I_clk),
    .rst_n      (I_rstn),
    .clear      (I_clear),
    .strobe_in  (push),
    .din        (vel_d),
    .dout       (O_velocity),
    .strobe_out (O_vel_valid)
  );

endmodule

// File: tb/tb_angle_tracker.sv
// Bench for angle_tracker: directed vectors, corner sequences and a
// cycle-level reference model checked against the DUT every cycle.
module tb_angle_tracker;

  localparam int AW = 12;
  localparam int TW = 4;
  localparam int PD = 4;
  localparam int VD = 16;
  localparam int FL = 2;
  localparam int PW = AW + TW;
  localparam longint SPAN  = 1 << AW;
  localparam longint PMAX  = (1 << (PW - 1)) - 1;
  localparam longint PMIN  = -(1 << (PW - 1));
  localparam int     DEPTH = 1 << FL;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic dir = 1'b0;
  logic [AW-1:0] ang = '0;
  logic signed [PW-1:0] position;
  logic signed [PW-1:0] velocity;
  logic pos_valid;
  logic vel_valid;
  logic sat;

  always #5 clk = ~clk;

  angle_tracker #(
    .ANGLE_W   (AW),
    .TURN_W    (TW),
    .POS_DIV   (PD),
    .VEL_DIV   (VD),
    .FILT_LOG2 (FL)
  ) dut (
    .I_clk       (clk),
    .I_rstn      (rstn),
    .I_angle     (ang),
    .I_dir       (dir),
    .I_clear     (clr),
    .O_position  (position),
    .O_pos_valid (pos_valid),
    .O_velocity  (velocity),
    .O_vel_valid (vel_valid),
    .O_sat       (sat)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(
    input string name,
    input logic signed [63:0] act,
    input logic signed [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic over whole revolutions.
  longint m_pos, m_vel, m_aprev, m_pref;
  bit     m_pv, m_vv, m_sat, m_pfirst, m_vfirst;
  int     m_cyc;
  longint hist[$];

  function automatic longint clampw(input longint v);
    if (v > PMAX) return PMAX;
    if (v < PMIN) return PMIN;
    return v;
  endfunction

  function automatic longint floordiv(input longint s, input longint n);
    longint q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q -= 1;
    return q;
  endfunction

  task automatic m_reset();
    m_pos = 0; m_vel = 0; m_aprev = 0; m_pref = 0;
    m_pv = 0; m_vv = 0; m_sat = 0;
    m_pfirst = 1; m_vfirst = 1; m_cyc = 0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(0);
  endtask

  task automatic m_step();
    longint pre, a, d, s;
    bit pt, vt;
    pre = m_pos;
    pt = (m_cyc % PD) == PD - 1;
    vt = (m_cyc % VD) == VD - 1;
    m_cyc++;
    m_pv = pt;
    m_vv = 0;
    if (pt) begin
      a = dir ? (SPAN - longint'(ang)) % SPAN : longint'(ang);
      if (m_pfirst) begin
        m_pos = a;
        m_pfirst = 0;
      end else begin
        d = ((a - m_aprev) % SPAN + SPAN) % SPAN;
        if (d >= SPAN / 2) d -= SPAN;
        s = m_pos + d;
        m_pos = clampw(s);
        if (m_pos != s) m_sat = 1;
      end
      m_aprev = a;
    end
    if (vt) begin
      if (m_vfirst) begin
        m_vfirst = 0;
      end else begin
        hist.push_front(clampw(pre - m_pref));
        void'(hist.pop_back());
        s = 0;
        foreach (hist[i]) s += hist[i];
        m_vel = floordiv(s, DEPTH);
        m_vv = 1;
      end
      m_pref = pre;
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge rstn) begin
    if (!rstn)    m_reset();
    else if (clr) m_reset();
    else          m_step();
  end

  bit mon_en = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_position", position, m_pos);
      check("mon_pos_valid", pos_valid, m_pv);
      check("mon_velocity", velocity, m_vel);
      check("mon_vel_valid", vel_valid, m_vv);
      check("mon_sat", sat, m_sat);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic wait_pos_valid();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pos_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL pos_valid_timeout: got none expected pulse");
  endtask

  task automatic pulse_clear(input logic [AW-1:0] a);
    ang = a;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic sat_run(input int step, input longint lim);
    int n;
    pulse_clear('0);
    n = 0;
    while (!sat && n < 1000) begin
      @(negedge clk);
      if (pos_valid) ang = AW'(int'(ang) + step);
      n++;
    end
    check("sat_flag", sat, 1);
    check("sat_position", position, lim);
    for (int i = 0; i < 2; i++) begin
      wait_pos_valid();
      check("sat_hold", position, lim);
    end
  endtask

  typedef struct {
    logic [AW-1:0] angle;
    logic          dir;
    logic          clr;
    int            exp_pos;
  } vec_t;

  vec_t tbl[14];
  int   nv;
  int   n;
  int   rate;
  int   expv[5];

  initial begin
    tbl[0]  = '{12'd100,  1'b0, 1'b0, 100};
    tbl[1]  = '{12'd100,  1'b0, 1'b0, 100};
    tbl[2]  = '{12'd100,  1'b0, 1'b0, 100};
    tbl[3]  = '{12'd4000, 1'b0, 1'b1, 4000};
    tbl[4]  = '{12'd50,   1'b0, 1'b0, 4146};
    tbl[5]  = '{12'd4000, 1'b0, 1'b0, 4000};
    tbl[6]  = '{12'd0,    1'b1, 1'b1, 0};
    tbl[7]  = '{12'd10,   1'b1, 1'b0, -10};
    tbl[8]  = '{12'd10,   1'b1, 1'b0, -10};
    tbl[9]  = '{12'd0,    1'b0, 1'b1, 0};
    tbl[10] = '{12'd2047, 1'b0, 1'b0, 2047};
    tbl[11] = '{12'd0,    1'b0, 1'b0, 0};
    tbl[12] = '{12'd2048, 1'b0, 1'b0, -2048};
    tbl[13] = '{12'd2048, 1'b1, 1'b0, -2048};
    expv = '{64, 128, 192, 256, 256};

    repeat (3) @(negedge clk);
    check("rst_position", position, 0);
    check("rst_velocity", velocity, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_vel_valid", vel_valid, 0);
    check("rst_sat", sat, 0);
    rstn = 1'b1;
    mon_en = 1;

    foreach (tbl[i]) begin
      dir = tbl[i].dir;
      if (tbl[i].clr) pulse_clear(tbl[i].angle);
      else            ang = tbl[i].angle;
      wait_pos_valid();
      check($sformatf("tbl%0d_pos", i), position, tbl[i].exp_pos);
    end

    // First averaged output only on the second velocity tick.
    dir = 1'b0;
    pulse_clear(12'd100);
    n = 0;
    while (!vel_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("vel_first_cycle", n, 2 * VD);
    check("vel_hold_zero", velocity, 0);

    pulse_clear('0);
    nv = 0;
    n = 0;
    while (nv < 5 && n < 300) begin
      @(negedge clk);
      if (pos_valid) ang = ang + 12'd64;
      if (vel_valid) begin
        check($sformatf("ramp%0d", nv), velocity, expv[nv]);
        nv++;
      end
      n++;
    end
    check("ramp_count", nv, 5);

    sat_run(2000, PMAX);
    ang = 12'd123;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_position", position, 0);
    check("clr_velocity", velocity, 0);
    check("clr_sat", sat, 0);
    check("clr_pos_valid", pos_valid, 0);
    wait_pos_valid();
    check("clr_reload", position, 123);
    sat_run(-2000, PMIN);

    // Reset lands inside a tick cycle: no valid may follow.
    pulse_clear(12'd500);
    wait_pos_valid();
    ang = 12'd900;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("arst_position", position, 0);
    check("arst_pos_valid", pos_valid, 0);
    check("arst_velocity", velocity, 0);
    @(negedge clk);
    check("arst_no_valid", pos_valid, 0);
    #1 rstn = 1'b1;
    wait_pos_valid();
    check("arst_reload", position, 900);

    rate = 3;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0)
        rate = int'($urandom_range(0, 1000)) - 500;
      ang = AW'(int'(ang) + rate);
      if ($urandom_range(0, 99) == 0) ang = AW'($urandom);
      if ($urandom_range(0, 499) == 0) dir = ~dir;
      clr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        #1 rstn = 1'b0;
        @(negedge clk);
        #1 rstn = 1'b1;
      end
    end
    clr = 1'b0;
    @(negedge clk);
    mon_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/angle_tracker.md
ANGLE_TRACKER -- requirements
Module: angle_tracker

Interface
REQ-001 SHALL have parameter ANGLE_W, default 12, single-turn angle width (0..2^ANGLE_W-1 = one revolution).
REQ-002 SHALL have parameter TURN_W, default 20, signed turn-count width; POS_W = ANGLE_W+TURN_W.
REQ-003 SHALL have parameter POS_DIV, default 400, I_clk cycles per position sample (>=2).
REQ-004 SHALL have parameter VEL_DIV, default 40000, I_clk cycles per velocity sample (>=2).
REQ-005 SHALL have parameter FILT_LOG2, default 2, velocity moving-average depth 2^FILT_LOG2 (0..4).
REQ-006 I_clk  in  1  sole clock; all logic on rising edge, no derived clocks.
REQ-007 I_rstn  in  1  asynchronous, active-low reset.
REQ-008 I_angle  in  ANGLE_W  unsigned mechanical angle from selected encoder.
REQ-009 I_dir  in  1  0: angle used as-is; 1: angle negated modulo 2^ANGLE_W.
REQ-010 I_clear  in  1  synchronous re-initialise (encoder switch / homing).
REQ-011 O_position  out  POS_W  signed multi-turn position, LSB = one angle count.
REQ-012 O_pos_valid  out  1  one-cycle pulse, O_position updated.
REQ-013 O_velocity  out  POS_W  signed averaged counts per velocity period.
REQ-014 O_vel_valid  out  1  one-cycle pulse, O_velocity updated.
REQ-015 O_sat  out  1  sticky: position accumulator saturated.

Function
REQ-016 Position tick SHALL assert when free-running counter (0..POS_DIV-1) equals POS_DIV-1; velocity tick likewise with independent counter (0..VEL_DIV-1).
REQ-017 On position tick, a = I_dir ? (2^ANGLE_W - I_angle) mod 2^ANGLE_W : I_angle; delta = (a - a_prev) truncated to ANGLE_W bits, read signed (range -2^(ANGLE_W-1)..2^(ANGLE_W-1)-1); a_prev <= a.
REQ-018 First position tick after reset/clear SHALL load O_position = zero-extended a, a_prev = a, no delta applied.
REQ-019 Later ticks SHALL set O_position += sign-extended delta, saturating at signed POS_W max/min; saturation sets O_sat.
REQ-020 O_pos_valid SHALL pulse in the cycle O_position takes its new value (one cycle after tick), including the first tick.
REQ-021 On velocity tick, d = O_position(current register value) - p_ref, saturated to POS_W signed; p_ref <= O_position.
REQ-022 First velocity tick after reset/clear SHALL only load p_ref; no push, no O_vel_valid.
REQ-023 Later velocity ticks SHALL push d into a 2^FILT_LOG2 delay line, sum += d - oldest, O_velocity = sum >>> FILT_LOG2 (arithmetic), O_vel_valid pulsed one cycle after tick.
REQ-024 Sum register SHALL be POS_W+FILT_LOG2 bits signed, never overflows; delay line starts all-zero so first 2^FILT_LOG2-1 outputs ramp.
REQ-025 Coincident position and velocity ticks: velocity SHALL use pre-update O_position of that cycle.
REQ-026 I_clear SHALL take priority over ticks: zero O_position, O_velocity, sum, delay line, O_sat, both valids; re-arm first-tick behaviour of REQ-018/022; divider counters restart at 0.

Reset
REQ-027 I_rstn low SHALL asynchronously force all outputs 0, counters 0, delay line and sum 0, first-tick flags armed.
REQ-028 Release of I_rstn SHALL be usable mid-operation; no tick within the first cycle after release.

Structure
REQ-029 Default parameter values and the wrap-delta/saturate helper widths SHALL live in shared package foc_pkg.
REQ-030 Moving-average filter SHALL be one sub-module, mavg_filter (parameters width, log2 depth; strobe-in, strobe-out).

Verification (ANGLE_W=12, TURN_W=4, POS_DIV=4, VEL_DIV=16, FILT_LOG2=2)
REQ-031 Reset, I_angle=100 held -> first O_pos_valid with O_position=100; subsequent ticks unchanged; O_vel_valid from 2nd velocity tick, O_velocity=0.
REQ-032 Angle steps 4000->50 across a tick -> delta +146, O_position=4146; reverse 50->4000 -> back to 4000.
REQ-033 I_dir=1, I_angle 0->10 -> O_position 0 then -10 (4096-10=4086 wraps to delta -10).
REQ-034 Angle advanced +64 per position tick (+256 per velocity period) -> O_velocity sequence 64,128,192,256,256.
REQ-035 Forward spin until position reaches 32767 -> O_position holds 32767, O_sat=1; I_clear pulse -> all outputs 0, next tick reloads I_angle.
REQ-036 I_rstn asserted between a tick and its valid -> outputs 0 immediately, no O_pos_valid pulse.
